// File: rtl/conv_share_arbiter_if.sv
// Requester, result and ConvUnit handshake bundle for conv_share_arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface conv_share_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int KERNEL_W = 64
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ*64-1:0]       req_data;
    logic [NUM_REQ*KERNEL_W-1:0] req_kernel;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [NUM_REQ-1:0]          rsp_ready;
    logic [127:0]                rsp_data;
    logic [63:0]                 conv_in_data;
    logic [KERNEL_W-1:0]         conv_kernel;
    logic                        conv_in_valid;
    logic                        conv_in_ready;
    logic [127:0]                conv_result;
    logic                        conv_out_valid;
    logic                        conv_out_ready;

    modport slave (
        input  req_valid, req_last, req_data, req_kernel, rsp_ready,
        input  conv_in_ready, conv_result, conv_out_valid,
        output req_ready, rsp_valid, rsp_data,
        output conv_in_data, conv_kernel, conv_in_valid, conv_out_ready
    );

    modport master (
        output req_valid, req_last, req_data, req_kernel, rsp_ready,
        output conv_in_ready, conv_result, conv_out_valid,
        input  req_ready, rsp_valid, rsp_data,
        input  conv_in_data, conv_kernel, conv_in_valid, conv_out_ready
    );
endinterface

// File: rtl/conv_share_arbiter.sv
// Round-robin job arbiter sharing one ConvUnit between requesters,
// with an owner-tag FIFO routing each result back to its issuer.
module conv_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int KERNEL_W  = 64,
    parameter int TAG_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    conv_share_arbiter_if.slave        bus,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_orphan
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(TAG_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      win_id;
    logic                found;
    logic [KERNEL_W-1:0] kernel_reg;
    logic [IDW-1:0]      tag_mem [TAG_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [IDW-1:0]      head;
    logic                fifo_full, fifo_empty;
    logic                sel_valid, sel_last;
    logic                accept, pop;

    assign fifo_full  = count == CW'(TAG_DEPTH);
    assign fifo_empty = count == '0;
    assign head       = tag_mem[rd_ptr];
    assign sel_valid  = bus.req_valid[grant_id];
    assign sel_last   = bus.req_last[grant_id];
    assign busy       = state == BUSY;

    assign bus.conv_in_data = bus.req_data[int'(grant_id)*64 +: 64];
    assign bus.conv_kernel  = kernel_reg;
    assign bus.rsp_data     = bus.conv_result;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        win_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.req_ready     = '0;
        bus.conv_in_valid = 1'b0;
        accept            = 1'b0;
        unique case (state)
            IDLE: if (found) state_nxt = BUSY;
            BUSY: begin
                bus.conv_in_valid       = sel_valid & ~fifo_full;
                bus.req_ready[grant_id] = bus.conv_in_ready & ~fifo_full;
                accept = bus.conv_in_valid & bus.conv_in_ready;
                if (accept && sel_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rstn) begin
            bus.req_ready     = '0;
            bus.conv_in_valid = 1'b0;
            accept            = 1'b0;
        end
    end

    // An empty FIFO still takes the result so a stray one cannot wedge the unit.
    always_comb begin
        bus.rsp_valid      = '0;
        bus.conv_out_ready = 1'b0;
        pop                = 1'b0;
        if (rstn) begin
            bus.conv_out_ready = fifo_empty | bus.rsp_ready[head];
            if (!fifo_empty) begin
                bus.rsp_valid[head] = bus.conv_out_valid;
                pop = bus.conv_out_valid & bus.rsp_ready[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            kernel_reg <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                grant_id   <= win_id;
                kernel_reg <= bus.req_kernel[int'(win_id)*KERNEL_W +: KERNEL_W];
            end
            if (accept) begin
                tag_mem[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + 1'b1;
                if (sel_last) begin
                    if (int'(grant_id) == NUM_REQ - 1) rr_ptr <= '0;
                    else rr_ptr <= grant_id + 1'b1;
                end
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
            if (bus.conv_out_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_share_arbiter.sv
// Bench for conv_share_arbiter: queued requester jobs, a ConvUnit model
// and a per-requester result scoreboard derived from the posted data.
module tb_conv_share_arbiter;
    localparam int N  = 4;
    localparam int KW = 64;

    logic       clk = 1'b0;
    logic       rstn;
    logic       busy;
    logic [1:0] grant_id;
    logic       err_orphan;

    conv_share_arbiter_if #(.NUM_REQ(N), .KERNEL_W(KW)) bus ();

    conv_share_arbiter #(.NUM_REQ(N), .KERNEL_W(KW), .TAG_DEPTH(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .busy       (busy),
        .grant_id   (grant_id),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [63:0] d; logic l;} beat_t;

    beat_t        jq[N][$];
    logic [127:0] exp_q[N][$];
    logic [63:0]  jobd[N][$];
    int           jlen[N][$];
    logic [127:0] cq[$];
    logic [63:0]  in_log[$];
    logic [KW-1:0] kern_log[$];
    int           grant_log[$];

    int           checks = 0;
    int           passed = 0;
    int           cq_n = 0;
    logic [127:0] head_r = '0;
    logic         busy_d = 1'b0;
    logic         in_rand = 1'b0, out_rand = 1'b0;
    logic         in_rdy = 1'b1, out_en = 1'b1, out_gate = 1'b0;
    logic         force_out = 1'b0;

    assign bus.conv_out_valid = (cq_n != 0 && out_gate) || force_out;
    assign bus.conv_result    = (cq_n != 0) ? head_r : 128'hbad0_0bad;

    function automatic logic [127:0] conv_f(input logic [63:0] d);
        return {~d, d ^ 64'h0123_4567_89ab_cdef};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic post(input int r, input int n);
        logic [63:0] d;
        jlen[r].push_back(n);
        for (int b = 0; b < n; b++) begin
            d = {$urandom, $urandom};
            jq[r].push_back('{d: d, l: (b == n - 1)});
            exp_q[r].push_back(conv_f(d));
            jobd[r].push_back(d);
        end
    endtask

    function automatic bit drained();
        bit e = (cq.size() == 0);
        for (int i = 0; i < N; i++)
            if (jq[i].size() != 0 || exp_q[i].size() != 0) e = 0;
        return e;
    endfunction

    // Beats must appear as whole jobs, in the given grant order.
    task automatic chk_jobs(input int eg[$]);
        int n;
        foreach (eg[j]) begin
            chk("grant_order", grant_log.size() > 0 ? grant_log.pop_front() : -1, eg[j]);
            n = jlen[eg[j]].pop_front();
            for (int b = 0; b < n; b++)
                chk("in_beat", in_log.size() > 0 ? in_log.pop_front() : 'x,
                    jobd[eg[j]].pop_front());
        end
    endtask

    // Requesters, ConvUnit and result monitor.
    always @(posedge clk) begin : mdl
        logic [N-1:0] racc, rhs;
        logic         iacc, oacc;
        logic [127:0] rd;
        racc = bus.req_valid & bus.req_ready;
        rhs  = bus.rsp_valid & bus.rsp_ready;
        iacc = bus.conv_in_valid & bus.conv_in_ready;
        oacc = bus.conv_out_valid & bus.conv_out_ready;
        rd   = bus.rsp_data;
        if (busy === 1'b1 && busy_d !== 1'b1) grant_log.push_back(int'(grant_id));
        busy_d = busy;
        if (oacc && cq.size() > 0) void'(cq.pop_front());
        if (iacc) begin
            in_log.push_back(bus.conv_in_data);
            kern_log.push_back(bus.conv_kernel);
            cq.push_back(conv_f(bus.conv_in_data));
        end
        for (int i = 0; i < N; i++)
            if (racc[i] && jq[i].size() > 0) void'(jq[i].pop_front());
        if (|bus.rsp_valid) chk("rsp_onehot", $countones(bus.rsp_valid), 1);
        for (int i = 0; i < N; i++) begin
            if (rhs[i]) begin
                if (exp_q[i].size() == 0) chk("rsp_extra", 0, 1);
                else chk("rsp_data", rd, exp_q[i].pop_front());
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = jq[i].size() > 0;
            bus.req_data[i*64 +: 64] = jq[i].size() > 0 ? jq[i][0].d : '0;
            bus.req_last[i]          = jq[i].size() > 0 ? jq[i][0].l : 1'b0;
        end
        bus.conv_in_ready = in_rand ? ($urandom_range(0, 3) != 0) : in_rdy;
        out_gate = out_rand ? ($urandom_range(0, 2) != 0) : out_en;
        cq_n   = cq.size();
        head_r = cq_n != 0 ? cq[0] : '0;
    end

    initial begin
        int cnt[N];
        int eg[$];
        int p, pick;
        logic [KW-1:0] k1;

        rstn = 1'b0;
        bus.rsp_ready = '1;
        for (int i = 0; i < N; i++) bus.req_kernel[i*KW +: KW] = {$urandom, $urandom};

        // Reset with every requester posting.
        post(0, 2); post(1, 2); post(2, 2); post(3, 2); post(0, 2);
        tick(3);
        chk("rst_req_valid", bus.req_valid, 4'hf);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_in_valid", bus.conv_in_valid, 0);
        chk("rst_out_ready", bus.conv_out_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_orphan", err_orphan, 0);

        // Round-robin over all requesters, random ConvUnit timing.
        cnt = '{2, 1, 1, 1};
        p = 0;
        for (int j = 0; j < 5; j++) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && cnt[(p + k) % N] > 0) pick = (p + k) % N;
            eg.push_back(pick);
            cnt[pick]--;
            p = (pick + 1) % N;
        end
        in_rand = 1'b1; out_rand = 1'b1;
        rstn = 1'b1;
        for (int t = 0; t < 400 && !(drained() && grant_log.size() >= 5); t++) tick();
        chk("rr_drained", drained(), 1);
        chk_jobs(eg);

        // Owner FIFO full while requester 1 is back-pressured.
        in_rand = 1'b0; out_rand = 1'b0;
        bus.rsp_ready = 4'b1101;
        post(1, 10);
        for (int t = 0; t < 50 && in_log.size() < 8; t++) tick();
        tick(3);
        chk("bp_accepted", in_log.size(), 8);
        chk("bp_in_valid", bus.conv_in_valid, 0);
        chk("bp_req_ready", bus.req_ready, 0);
        chk("bp_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("bp_busy", busy, 1);
        bus.rsp_ready = '1;
        for (int t = 0; t < 100 && !drained(); t++) tick();
        chk("bp_drained", drained(), 1);
        eg = '{1};
        chk_jobs(eg);

        // Kernel latched at grant survives a mid-job change.
        k1 = {$urandom, $urandom};
        bus.req_kernel[2*KW +: KW] = k1;
        kern_log.delete();
        in_rand = 1'b1; out_rand = 1'b1;
        post(2, 6);
        for (int t = 0; t < 100 && in_log.size() < 2; t++) tick();
        bus.req_kernel[2*KW +: KW] = ~k1;
        for (int t = 0; t < 200 && !drained(); t++) tick();
        chk("kh_drained", drained(), 1);
        chk("kh_beats", kern_log.size(), 6);
        foreach (kern_log[j]) chk("kh_kernel", kern_log[j], k1);
        eg = '{2};
        chk_jobs(eg);

        // Orphan result with the owner FIFO empty.
        in_rand = 1'b0; out_rand = 1'b0;
        tick(2);
        force_out = 1'b1;
        #1;
        chk("orph_rsp_valid", bus.rsp_valid, 0);
        chk("orph_out_ready", bus.conv_out_ready, 1);
        chk("orph_pre", err_orphan, 0);
        tick();
        force_out = 1'b0;
        chk("orph_set", err_orphan, 1);
        tick(3);
        chk("orph_sticky", err_orphan, 1);

        // Reset after 3 of 5 beats; rr pointer and FIFO restart.
        out_en = 1'b0;
        post(0, 5);
        for (int t = 0; t < 50 && in_log.size() < 3; t++) tick();
        rstn = 1'b0;
        #1;
        chk("mr_in_valid", bus.conv_in_valid, 0);
        chk("mr_req_ready", bus.req_ready, 0);
        tick(2);
        chk("mr_busy", busy, 0);
        chk("mr_grant", grant_id, 0);
        chk("mr_orphan_clr", err_orphan, 0);
        chk("mr_first_grant", grant_log.size() > 0 ? grant_log.pop_front() : -1, 0);
        chk("mr_beats", in_log.size(), 3);
        for (int b = 0; b < 3; b++)
            chk("mr_beat", in_log.size() > 0 ? in_log.pop_front() : 'x,
                jobd[0].pop_front());
        jq[0].delete(); exp_q[0].delete(); jobd[0].delete(); jlen[0].delete();
        cq.delete();
        bus.rsp_ready = '0;
        tick();
        rstn = 1'b1;
        #1;
        chk("mr_fifo_empty", bus.conv_out_ready, 1);
        tick();
        chk("mr_no_orphan", err_orphan, 0);
        bus.rsp_ready = '1;
        out_en = 1'b1;
        post(3, 1); post(2, 1);
        for (int t = 0; t < 50 && busy !== 1'b1; t++) tick();
        chk("mr_grant2", grant_id, 2);
        for (int t = 0; t < 100 && !(drained() && grant_log.size() >= 2); t++) tick();
        chk("mr_drained", drained(), 1);
        eg = '{2, 3};
        chk_jobs(eg);
        chk("mr_orphan_end", err_orphan, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
